alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Execute-stage sequencer that drives the ALU's operand and control inputs. It accepts one decoded instruction slice per handshake and generates the 4-bit ALU_control code from opcode/funct fields. It registers the operands onto the ALU port, captures ALU_result/zero one cycle later, and returns the result plus a branch-taken flag through a valid/ready output handshake. It sits between the register-read stage and writeback/branch resolution and owns the ALU's input side.

Parameters:
XLEN, 32, datapath width of operands and result
CTRL_W, 4, width of ALU_control

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  block can accept (high only in IDLE)
opcode  in  7  instruction[6:0]
funct3  in  3  instruction[14:12]
funct7_5  in  1  instruction[30]
rs1_val  in  XLEN  register rs1 value
rs2_val  in  XLEN  register rs2 value
imm  in  XLEN  sign-extended immediate
rs1_data  out  XLEN  registered operand A to ALU
source2_data  out  XLEN  registered operand B to ALU (rs2_val or imm)
ALU_control  out  CTRL_W  registered ALU op code
ALU_result  in  XLEN  combinational result from ALU
zero  in  1  ALU zero flag
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  XLEN  captured ALU_result
branch_taken  out  1  branch decision (0 for non-branches)
illegal  out  1  unsupported opcode/funct combination

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rs1_data, source2_data, result = 0; ALU_control=4'b0010; out_valid, branch_taken, illegal = 0. in_ready=1 once in IDLE.
- ALU codes: ADD 0010, SUB 0110, AND 0000, OR 0001.
- Decode:
  - R-type 0110011: f3 000 → ADD if funct7_5=0, SUB if 1; 111 → AND; 110 → OR; else illegal. Operand B = rs2_val.
  - I-ALU 0010011: f3 000 ADD, 111 AND, 110 OR, else illegal; funct7_5 ignored. Operand B = imm.
  - Load 0000011 / store 0100011: ADD, B = imm.
  - Branch 1100011: SUB, B = rs2_val. f3 000 (BEQ) → taken = zero; f3 001 (BNE) → taken = !zero; other f3 → illegal.
  - Any other opcode → illegal.
  - Illegal: ALU_control=ADD, result forced to 0, branch_taken=0, illegal=1.
- FSM:
  - IDLE: in_ready=1. On in_valid, register operands, ALU_control, branch kind and illegal flag; go to EXEC.
  - EXEC: ALU inputs are stable from registers. At the clock edge, capture ALU_result→result and compute branch_taken from zero; go to DONE.
  - DONE: out_valid=1; result, branch_taken and illegal are held stable. On out_ready, go to IDLE with out_valid=0 on the next cycle.
- Latency: accept edge N → out_valid high from cycle N+2. Minimum issue interval is 3 cycles when out_ready is held high.
- Backpressure: DONE is held indefinitely with all outputs stable. in_ready stays 0, and in_valid is ignored outside IDLE.
- ALU-facing registers keep the last issued values until the next accept; they are not cleared in IDLE.
- Reset asserted mid-operation aborts immediately to reset values. No partial result is ever presented.
- Arithmetic is modulo 2^XLEN; no overflow flag.

Decomposition:
- Package alu_pkg holds:
  - ALU_control localparams (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR)
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH)
  - funct3 constants
  - state enum (IDLE, EXEC, DONE)
  - branch-kind enum (BR_NONE, BR_EQ, BR_NE)
- One combinational sub-module, alu_op_decode, maps opcode/funct3/funct7_5 to ALU_control, src2-is-imm, branch kind and illegal. The sequencer instantiates it alongside the FSM.

Test Plan:
- R-type ADD: rs1=5, rs2=7, f3=000, f7_5=0 → ALU_control=0010, source2_data=7, result=12, out_valid exactly 2 cycles after accept.
- R-type SUB wrap: rs1=0, rs2=1, f7_5=1 → ALU_control=0110, result=32'hFFFFFFFF. I-type ORI with rs1=32'hF0, imm=32'h0F → ALU_control=0001, result=32'hFF.
- BEQ rs1=rs2=32'h1234 → result=0, branch_taken=1. BNE with the same operands → branch_taken=0. BEQ 3 vs 4 → branch_taken=0.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid, result and branch_taken stable, in_ready=0, second in_valid ignored. out_ready=1 → IDLE, then the second instruction is accepted.
- Illegal: opcode 1110011, or R-type f3=001 → illegal=1, result=0, ALU_control=0010, branch_taken=0.
- Reset mid-EXEC: rst_n low asynchronously → out_valid=0, ALU_control=0010, in_ready=1 after release; next instruction completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-stage ALU issue sequencer.
package alu_pkg;

    // ALU_control encodings understood by the ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Major opcodes (instruction[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 values (instruction[14:12])
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // How the zero flag turns into a branch decision
    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2
    } br_kind_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7_5 into ALU control, operand-B
// source, branch kind and an illegal flag. Illegal encodings always decode to
// ADD with no branch so nothing downstream can act on them.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] alu_ctrl_o,
    output logic       src2_is_imm_o,
    output br_kind_t   br_kind_o,
    output logic       illegal_o
);

    // Opcode/funct decode table, safe defaults first
    always_comb begin
        alu_ctrl_o    = ALU_ADD;
        src2_is_imm_o = 1'b0;
        br_kind_o     = BR_NONE;
        illegal_o     = 1'b0;
        case (opcode_i)
            OP_R: begin
                case (funct3_i)
                    F3_ADD:  alu_ctrl_o = funct7_5_i ? ALU_SUB : ALU_ADD;
                    F3_AND:  alu_ctrl_o = ALU_AND;
                    F3_OR:   alu_ctrl_o = ALU_OR;
                    default: illegal_o  = 1'b1;
                endcase
            end
            OP_I: begin
                src2_is_imm_o = 1'b1;
                // funct7_5 is part of the immediate here, so it is not decoded
                case (funct3_i)
                    F3_ADD:  alu_ctrl_o = ALU_ADD;
                    F3_AND:  alu_ctrl_o = ALU_AND;
                    F3_OR:   alu_ctrl_o = ALU_OR;
                    default: illegal_o  = 1'b1;
                endcase
            end
            OP_LOAD, OP_STORE: begin
                src2_is_imm_o = 1'b1;
                alu_ctrl_o    = ALU_ADD;
            end
            OP_BRANCH: begin
                case (funct3_i)
                    F3_BEQ: begin
                        alu_ctrl_o = ALU_SUB;
                        br_kind_o  = BR_EQ;
                    end
                    F3_BNE: begin
                        alu_ctrl_o = ALU_SUB;
                        br_kind_o  = BR_NE;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer owning the ALU input side.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, out_valid only in DONE, and once
// out_valid rises it and all result outputs stay stable until out_ready.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   source2_data,
    output logic [CTRL_W-1:0] ALU_control,
    input  logic [XLEN-1:0]   ALU_result,
    input  logic              zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              branch_taken,
    output logic              illegal,
    output logic [1:0]        dbg_state_o
);

    state_t          state_q, state_d;
    logic            accept, capture;

    logic [3:0]      dec_ctrl;
    logic            dec_src2_imm;
    br_kind_t        dec_br_kind;
    logic            dec_illegal;

    logic [XLEN-1:0]   rs1_data_q, src2_q, result_q;
    logic [XLEN-1:0]   src2_d, result_d;
    logic [CTRL_W-1:0] ctrl_q;
    br_kind_t          br_kind_q;
    logic              illegal_q, taken_q, taken_d;

    alu_op_decode u_decode (
        .opcode_i      (opcode),
        .funct3_i      (funct3),
        .funct7_5_i    (funct7_5),
        .alu_ctrl_o    (dec_ctrl),
        .src2_is_imm_o (dec_src2_imm),
        .br_kind_o     (dec_br_kind),
        .illegal_o     (dec_illegal)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state, handshake outputs and register-load strobes
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                capture = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand-B select and EXEC-cycle result/branch evaluation
    always_comb begin
        src2_d   = dec_src2_imm ? imm : rs2_val;
        result_d = illegal_q ? '0 : ALU_result;
        case (br_kind_q)
            BR_EQ:   taken_d = zero;
            BR_NE:   taken_d = !zero;
            default: taken_d = 1'b0;
        endcase
        if (illegal_q) taken_d = 1'b0;
    end

    // ALU-facing registers load on accept and persist until the next accept;
    // result registers load only in EXEC so DONE outputs never move
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_data_q <= '0;
            src2_q     <= '0;
            ctrl_q     <= CTRL_W'(ALU_ADD);
            br_kind_q  <= BR_NONE;
            illegal_q  <= 1'b0;
            result_q   <= '0;
            taken_q    <= 1'b0;
        end else begin
            if (accept) begin
                rs1_data_q <= rs1_val;
                src2_q     <= src2_d;
                ctrl_q     <= CTRL_W'(dec_ctrl);
                br_kind_q  <= dec_br_kind;
                illegal_q  <= dec_illegal;
            end
            if (capture) begin
                result_q <= result_d;
                taken_q  <= taken_d;
            end
        end
    end

    assign rs1_data     = rs1_data_q;
    assign source2_data = src2_q;
    assign ALU_control  = ctrl_q;
    assign result       = result_q;
    assign branch_taken = taken_q;
    assign illegal      = illegal_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU attached to the
// operand/control outputs and a scoreboard of expected results.
module tb_alu_issue_ctrl;

    localparam int XLEN = 32;

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [6:0]      opcode = '0;
    logic [2:0]      funct3 = '0;
    logic            funct7_5 = 1'b0;
    logic [XLEN-1:0] rs1_val = '0, rs2_val = '0, imm = '0;
    logic [XLEN-1:0] rs1_data, source2_data;
    logic [3:0]      ALU_control;
    logic [XLEN-1:0] ALU_result;
    logic            zero;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            branch_taken, illegal;
    logic [1:0]      dbg_state;

    alu_issue_ctrl #(.XLEN(XLEN), .CTRL_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .rs1_val      (rs1_val),
        .rs2_val      (rs2_val),
        .imm          (imm),
        .rs1_data     (rs1_data),
        .source2_data (source2_data),
        .ALU_control  (ALU_control),
        .ALU_result   (ALU_result),
        .zero         (zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .dbg_state_o  (dbg_state)
    );

    // Behavioural ALU driven by the DUT's registered operand/control outputs
    always_comb begin
        case (ALU_control)
            4'b0010: ALU_result = rs1_data + source2_data;
            4'b0110: ALU_result = rs1_data - source2_data;
            4'b0000: ALU_result = rs1_data & source2_data;
            4'b0001: ALU_result = rs1_data | source2_data;
            default: ALU_result = '0;
        endcase
        zero = (ALU_result == '0);
    end

    // Scoreboard
    int tests = 0;
    int fails = 0;
    logic [XLEN-1:0] exp_q[$];
    logic            exp_tk_q[$];
    logic            exp_il_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] im);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f75;
        rs1_val  = a;
        rs2_val  = b;
        imm      = im;
    endtask

    // Inputs already driven with in_valid high; takes the accept edge and
    // checks the EXEC cycle and the arrival of out_valid one edge later
    task automatic accept(input string tag, input logic [3:0] e_ctrl, input logic chk_s2,
                          input logic [XLEN-1:0] e_a, input logic [XLEN-1:0] e_s2,
                          input logic [XLEN-1:0] e_res, input logic e_tk, input logic e_il);
        chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        exp_q.push_back(e_res);
        exp_tk_q.push_back(e_tk);
        exp_il_q.push_back(e_il);
        chk({tag, ":state_exec"}, 32'(dbg_state), 32'd1);
        chk({tag, ":ctrl"}, 32'(ALU_control), 32'(e_ctrl));
        chk({tag, ":rs1_data"}, rs1_data, e_a);
        if (chk_s2) chk({tag, ":src2"}, source2_data, e_s2);
        chk({tag, ":exec_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ":exec_in_ready"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, ":latency_out_valid"}, 32'(out_valid), 32'd1);
    endtask

    // Complete the output handshake and compare against the scoreboard
    task automatic collect(input string tag);
        out_ready = 1'b1;
        chk({tag, ":q_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            chk({tag, ":result"}, result, exp_q.pop_front());
            chk({tag, ":taken"}, 32'(branch_taken), 32'(exp_tk_q.pop_front()));
            chk({tag, ":illegal"}, 32'(illegal), 32'(exp_il_q.pop_front()));
        end
        step();
        out_ready = 1'b0;
        chk({tag, ":post_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ":post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic f75, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] im, input logic [3:0] e_ctrl, input logic chk_s2,
                         input logic [XLEN-1:0] e_s2, input logic [XLEN-1:0] e_res,
                         input logic e_tk, input logic e_il);
        drive(op, f3, f75, a, b, im);
        in_valid = 1'b1;
        accept(tag, e_ctrl, chk_s2, a, e_s2, e_res, e_tk, e_il);
        collect(tag);
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst:in_ready", 32'(in_ready), 32'd1);
        chk("rst:out_valid", 32'(out_valid), 32'd0);
        chk("rst:ctrl", 32'(ALU_control), 32'h2);
        chk("rst:result", result, 32'd0);
        chk("rst:rs1_data", rs1_data, 32'd0);
        chk("rst:src2", source2_data, 32'd0);
        chk("rst:taken", 32'(branch_taken), 32'd0);
        chk("rst:illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Arithmetic / logic
        issue("add", 7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd99, 4'b0010, 1'b1, 32'd7, 32'd12, 1'b0, 1'b0);
        issue("sub_wrap", 7'b0110011, 3'b000, 1'b1, 32'd0, 32'd1, 32'd99, 4'b0110, 1'b1, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue("ori", 7'b0010011, 3'b110, 1'b0, 32'hF0, 32'h55, 32'h0F, 4'b0001, 1'b1, 32'h0F, 32'hFF, 1'b0, 1'b0);
        issue("and_r", 7'b0110011, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 4'b0000, 1'b1, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0);
        issue("addi_f75", 7'b0010011, 3'b000, 1'b1, 32'd10, 32'd1000, 32'hFFFF_FFFE, 4'b0010, 1'b1, 32'hFFFF_FFFE, 32'd8, 1'b0, 1'b0);
        issue("load", 7'b0000011, 3'b010, 1'b0, 32'h1000, 32'h7, 32'h24, 4'b0010, 1'b1, 32'h24, 32'h1024, 1'b0, 1'b0);
        issue("store", 7'b0100011, 3'b010, 1'b0, 32'h2000, 32'h7, 32'h8, 4'b0010, 1'b1, 32'h8, 32'h2008, 1'b0, 1'b0);

        // Branches
        issue("beq_eq", 7'b1100011, 3'b000, 1'b0, 32'h1234, 32'h1234, 32'h40, 4'b0110, 1'b1, 32'h1234, 32'd0, 1'b1, 1'b0);
        issue("bne_eq", 7'b1100011, 3'b001, 1'b0, 32'h1234, 32'h1234, 32'h40, 4'b0110, 1'b1, 32'h1234, 32'd0, 1'b0, 1'b0);
        issue("beq_ne", 7'b1100011, 3'b000, 1'b0, 32'd3, 32'd4, 32'h40, 4'b0110, 1'b1, 32'd4, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue("bne_ne", 7'b1100011, 3'b001, 1'b0, 32'd3, 32'd4, 32'h40, 4'b0110, 1'b1, 32'd4, 32'hFFFF_FFFF, 1'b1, 1'b0);

        // Illegal encodings
        issue("ill_op", 7'b1110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd1, 4'b0010, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        issue("ill_r_f3", 7'b0110011, 3'b001, 1'b0, 32'd5, 32'd7, 32'd1, 4'b0010, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        issue("ill_br_f3", 7'b1100011, 3'b010, 1'b0, 32'd9, 32'd9, 32'd1, 4'b0010, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        issue("ill_i_f3", 7'b0010011, 3'b100, 1'b0, 32'd9, 32'd9, 32'd1, 4'b0010, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Backpressure: hold DONE while a second instruction waits
        drive(7'b0110011, 3'b000, 1'b0, 32'd100, 32'd23, 32'd0);
        in_valid = 1'b1;
        accept("bp1", 4'b0010, 1'b1, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0);
        drive(7'b0110011, 3'b110, 1'b0, 32'hA0, 32'h0B, 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp:out_valid", 32'(out_valid), 32'd1);
            chk("bp:result", result, 32'd123);
            chk("bp:taken", 32'(branch_taken), 32'd0);
            chk("bp:in_ready", 32'(in_ready), 32'd0);
            chk("bp:rs1_hold", rs1_data, 32'd100);
            chk("bp:ctrl_hold", 32'(ALU_control), 32'h2);
            step();
        end
        collect("bp1");
        accept("bp2", 4'b0001, 1'b1, 32'hA0, 32'h0B, 32'hAB, 1'b0, 1'b0);
        collect("bp2");

        // Asynchronous reset in the middle of EXEC
        drive(7'b0110011, 3'b000, 1'b1, 32'd50, 32'd8, 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rst_mid:exec", 32'(dbg_state), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid:out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid:ctrl", 32'(ALU_control), 32'h2);
        chk("rst_mid:result", result, 32'd0);
        chk("rst_mid:rs1_data", rs1_data, 32'd0);
        chk("rst_mid:state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_mid:in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid:out_valid_after", 32'(out_valid), 32'd0);
        issue("post_rst_add", 7'b0110011, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'd0, 4'b0010, 1'b1, 32'd1, 32'h8000_0000, 1'b0, 1'b0);

        chk("end:q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
